// File: rtl/piano_key_decoder.sv
// piano_key_decoder: turns UART key bytes into a tone command (note, octave, stop).
// rx_done is synchronised, bytes are queued in a 4-deep FIFO and decoded one per 3 cycles.
`timescale 1ns/1ps
module piano_key_decoder #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_done,
  output logic        note_on,
  output logic [17:0] half_period,
  output logic [2:0]  note_idx,
  output logic [1:0]  octave,
  output logic        overflow,
  output logic        cmd_err
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DECODE, APPLY} state_t;
  typedef enum logic [2:0] {CLS_NOTE, CLS_STOP, CLS_DOWN, CLS_UP, CLS_ERR} cls_t;

  state_t        state;
  cls_t          cls;
  logic [2:0]    cls_idx;
  logic [7:0]    byte_r;
  logic          s1, s2, s3;
  logic [7:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  logic [HW-1:0] hold;
  logic          push, pop, full, push_ok;

  // Half-period table is specified at 100 MHz and rescaled for other clock rates.
  function automatic logic [17:0] base_period(input logic [2:0] idx);
    longint base;
    case (idx)
      3'd0:    base = 64'd191113;
      3'd1:    base = 64'd170262;
      3'd2:    base = 64'd151686;
      3'd3:    base = 64'd143172;
      3'd4:    base = 64'd127553;
      3'd5:    base = 64'd113636;
      3'd6:    base = 64'd101238;
      default: base = 64'd95556;
    endcase
    return 18'((base * longint'(CLK_HZ)) / 64'd100_000_000);
  endfunction

  assign push    = s2 & ~s3;
  assign pop     = (state == IDLE) && (count != 3'd0);
  assign full    = (count == 3'd4);
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      s1 <= rx_done;
      s2 <= s1;
      s3 <= s2;
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // When full, a simultaneous pop frees the slot being written; the read sees the old byte.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cls         <= CLS_ERR;
      cls_idx     <= 3'd0;
      byte_r      <= 8'd0;
      note_on     <= 1'b0;
      half_period <= 18'd0;
      note_idx    <= 3'd0;
      octave      <= 2'd0;
      cmd_err     <= 1'b0;
      hold        <= '0;
    end else begin
      cmd_err <= 1'b0;
      if (note_on && hold != '0) begin
        hold <= hold - HW'(1);
        if (hold == HW'(1)) note_on <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pop) begin
            byte_r <= mem[rd_ptr];
            state  <= DECODE;
          end
        end
        DECODE: begin
          cls     <= CLS_ERR;
          cls_idx <= 3'd0;
          case (byte_r)
            "a": begin cls <= CLS_NOTE; cls_idx <= 3'd0; end
            "s": begin cls <= CLS_NOTE; cls_idx <= 3'd1; end
            "d": begin cls <= CLS_NOTE; cls_idx <= 3'd2; end
            "f": begin cls <= CLS_NOTE; cls_idx <= 3'd3; end
            "g": begin cls <= CLS_NOTE; cls_idx <= 3'd4; end
            "h": begin cls <= CLS_NOTE; cls_idx <= 3'd5; end
            "j": begin cls <= CLS_NOTE; cls_idx <= 3'd6; end
            "k": begin cls <= CLS_NOTE; cls_idx <= 3'd7; end
            "0", " ": cls <= CLS_STOP;
            "z":      cls <= CLS_DOWN;
            "x":      cls <= CLS_UP;
            default:  cls <= CLS_ERR;
          endcase
          state <= APPLY;
        end
        APPLY: begin
          // Assignments here come after the hold timer so a new note beats a same-cycle expiry.
          case (cls)
            CLS_NOTE: begin
              note_idx    <= cls_idx;
              half_period <= base_period(cls_idx) >> octave;
              note_on     <= 1'b1;
              hold        <= HW'(HOLD_CYCLES);
            end
            CLS_STOP: begin
              note_on <= 1'b0;
              hold    <= '0;
            end
            CLS_DOWN: begin
              if (octave != 2'd0) begin
                octave      <= octave - 2'd1;
                half_period <= base_period(note_idx) >> (octave - 2'd1);
              end
            end
            CLS_UP: begin
              if (octave != 2'd2) begin
                octave      <= octave + 2'd1;
                half_period <= base_period(note_idx) >> (octave + 2'd1);
              end
            end
            default: cmd_err <= 1'b1;
          endcase
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
